// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit ALU between two requesters.
// Latches the winner's operands, pulses alu_en once, waits ALU_LAT cycles, returns the result.
module alu_share_arbiter #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       cin0,
  input  logic [3:0] op0,
  output logic       done0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       cin1,
  input  logic [3:0] op1,
  output logic       done1,
  output logic [3:0] result,
  output logic       grant_id,
  output logic       busy,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [3:0] alu_op,
  output logic       alu_en,
  input  logic [3:0] alu_y
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT3 = 3'(ALU_LAT);

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_op_q, alu_op_d;
  logic       alu_cin_q, alu_cin_d, alu_en_q, alu_en_d;
  logic [3:0] result_q, result_d;
  logic       grant_q, grant_d;
  logic       done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
  logic       win_s;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    alu_op_d     = alu_op_q;
    alu_en_d     = 1'b0;
    result_d     = result_q;
    grant_d      = grant_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    // On a tie the requester that did not win last time goes next.
    win_s        = (req0 && req1) ? ~last_grant_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d   = win_s;
          alu_a_d   = win_s ? a1 : a0;
          alu_b_d   = win_s ? b1 : b0;
          alu_cin_d = win_s ? cin1 : cin0;
          alu_op_d  = win_s ? op1 : op0;
          alu_en_d  = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT3;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          result_d = alu_y;
          done0_d  = ~grant_q;
          done1_d  = grant_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      alu_a_q      <= 4'd0;
      alu_b_q      <= 4'd0;
      alu_cin_q    <= 1'b0;
      alu_op_q     <= 4'd0;
      alu_en_q     <= 1'b0;
      result_q     <= 4'd0;
      grant_q      <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      alu_op_q     <= alu_op_d;
      alu_en_q     <= alu_en_d;
      result_q     <= result_d;
      grant_q      <= grant_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign result   = result_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_cin  = alu_cin_q;
  assign alu_op   = alu_op_q;
  assign alu_en   = alu_en_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each fed by a small adder model whose output is delayed by the configured latency.
module tb_alu_share_arbiter;

  logic clk, reset;
  logic [3:0] a0, b0, op0, a1, b1, op1;
  logic cin0, cin1;
  logic r1_req0, r1_req1, r3_req0, r3_req1;

  logic o1_done0, o1_done1, o1_grant, o1_busy, o1_cin, o1_en;
  logic [3:0] o1_result, o1_a, o1_b, o1_op, y1;
  logic o3_done0, o3_done1, o3_grant, o3_busy, o3_cin, o3_en;
  logic [3:0] o3_result, o3_a, o3_b, o3_op, y3;

  logic [3:0] p1;
  logic [3:0] p3 [3];

  int n_cmp = 0;
  int n_bad = 0;
  logic sel3;

  alu_share_arbiter #(.ALU_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .req0(r1_req0), .a0(a0), .b0(b0), .cin0(cin0), .op0(op0), .done0(o1_done0),
    .req1(r1_req1), .a1(a1), .b1(b1), .cin1(cin1), .op1(op1), .done1(o1_done1),
    .result(o1_result), .grant_id(o1_grant), .busy(o1_busy),
    .alu_a(o1_a), .alu_b(o1_b), .alu_cin(o1_cin), .alu_op(o1_op), .alu_en(o1_en),
    .alu_y(y1)
  );

  alu_share_arbiter #(.ALU_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .req0(r3_req0), .a0(a0), .b0(b0), .cin0(cin0), .op0(op0), .done0(o3_done0),
    .req1(r3_req1), .a1(a1), .b1(b1), .cin1(cin1), .op1(op1), .done1(o3_done1),
    .result(o3_result), .grant_id(o3_grant), .busy(o3_busy),
    .alu_a(o3_a), .alu_b(o3_b), .alu_cin(o3_cin), .alu_op(o3_op), .alu_en(o3_en),
    .alu_y(y3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU models: sum registered on the enable edge, then delayed to the configured latency.
  always @(posedge clk) begin
    if (reset) begin
      p1 <= 4'd0;
      p3[0] <= 4'd0; p3[1] <= 4'd0; p3[2] <= 4'd0;
    end else begin
      if (o1_en) p1 <= o1_a + o1_b + {3'd0, o1_cin};
      if (o3_en) p3[0] <= o3_a + o3_b + {3'd0, o3_cin};
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign y1 = p1;
  assign y3 = p3[2];

  logic m_done0, m_done1, m_grant, m_busy, m_cin, m_en;
  logic [3:0] m_result, m_a, m_b, m_op;
  assign m_done0  = sel3 ? o3_done0  : o1_done0;
  assign m_done1  = sel3 ? o3_done1  : o1_done1;
  assign m_grant  = sel3 ? o3_grant  : o1_grant;
  assign m_busy   = sel3 ? o3_busy   : o1_busy;
  assign m_cin    = sel3 ? o3_cin    : o1_cin;
  assign m_en     = sel3 ? o3_en     : o1_en;
  assign m_result = sel3 ? o3_result : o1_result;
  assign m_a      = sel3 ? o3_a      : o1_a;
  assign m_b      = sel3 ? o3_b      : o1_b;
  assign m_op     = sel3 ? o3_op     : o1_op;

  typedef struct {
    logic rq0, rq1;
    logic [3:0] a0, b0; logic c0; logic [3:0] op0;
    logic [3:0] a1, b1; logic c1; logic [3:0] op1;
    logic eg; logic [3:0] er;
    logic keep, chg;
  } vec_t;

  vec_t tbl [7];
  vec_t hold [4];
  vec_t t3 [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic q0, input logic q1);
    if (sel3) begin r3_req0 = q0; r3_req1 = q1; end
    else begin r1_req0 = q0; r1_req1 = q1; end
  endtask

  task automatic run_tx(input vec_t v, input int lat, input string nm);
    int n, en_cnt;
    bit got;
    logic [3:0] ea, eb, eo;
    logic ec;
    ea = v.eg ? v.a1 : v.a0;
    eb = v.eg ? v.b1 : v.b0;
    ec = v.eg ? v.c1 : v.c0;
    eo = v.eg ? v.op1 : v.op0;
    @(negedge clk);
    a0 = v.a0; b0 = v.b0; cin0 = v.c0; op0 = v.op0;
    a1 = v.a1; b1 = v.b1; cin1 = v.c1; op1 = v.op1;
    set_req(v.rq0, v.rq1);
    n = 0; en_cnt = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      chk({nm, "_alu_a_hold"}, m_a, ea);
      chk({nm, "_alu_b_hold"}, m_b, eb);
      chk({nm, "_done_overlap"}, m_done0 & m_done1, 0);
      if (m_en) begin
        en_cnt++;
        chk({nm, "_en_cycle"}, n, 1);
        chk({nm, "_alu_cin"}, m_cin, ec);
        chk({nm, "_alu_op"}, m_op, eo);
      end
      if (m_done0 || m_done1) begin
        got = 1'b1;
        chk({nm, "_latency"}, n, 2 + lat);
        chk({nm, "_done0"}, m_done0, !v.eg);
        chk({nm, "_done1"}, m_done1, v.eg);
        chk({nm, "_result"}, m_result, v.er);
        chk({nm, "_grant_id"}, m_grant, v.eg);
        chk({nm, "_en_count"}, en_cnt, 1);
        chk({nm, "_busy"}, m_busy, 1);
      end
      if (v.chg && n == 2) begin
        a0 = 4'd9; a1 = 4'd9;
        set_req(1'b0, 1'b0);
      end
    end
    if (!got) chk({nm, "_timeout"}, 1, 0);
    if (!v.keep) begin
      set_req(1'b0, 1'b0);
      @(negedge clk);
      chk({nm, "_done_clear"}, m_done0 | m_done1, 0);
      chk({nm, "_idle"}, m_busy, 0);
      chk({nm, "_result_hold"}, m_result, v.er);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1,1'b0, 4'd3,4'd5,1'b0,4'h1, 4'd0,4'd0,1'b0,4'h2, 1'b0,4'd8,  1'b0,1'b0};
    tbl[1] = '{1'b0,1'b1, 4'd0,4'd0,1'b0,4'h1, 4'd7,4'd6,1'b1,4'h2, 1'b1,4'd14, 1'b0,1'b0};
    tbl[2] = '{1'b1,1'b1, 4'd15,4'd1,1'b0,4'h1, 4'd4,4'd4,1'b0,4'h2, 1'b0,4'd0, 1'b0,1'b0};
    tbl[3] = '{1'b1,1'b1, 4'd1,4'd2,1'b0,4'h1, 4'd9,4'd2,1'b1,4'h2, 1'b1,4'd12, 1'b0,1'b0};
    tbl[4] = '{1'b1,1'b0, 4'd1,4'd1,1'b1,4'h1, 4'd0,4'd0,1'b0,4'h2, 1'b0,4'd3,  1'b0,1'b0};
    tbl[5] = '{1'b1,1'b0, 4'd6,4'd2,1'b0,4'h1, 4'd0,4'd0,1'b0,4'h2, 1'b0,4'd8,  1'b0,1'b0};
    tbl[6] = '{1'b0,1'b1, 4'd0,4'd0,1'b0,4'h1, 4'd2,4'd1,1'b0,4'h2, 1'b1,4'd3,  1'b0,1'b1};
    hold[0] = '{1'b1,1'b1, 4'd1,4'd1,1'b0,4'h1, 4'd3,4'd4,1'b0,4'h2, 1'b0,4'd2, 1'b1,1'b0};
    hold[1] = '{1'b1,1'b1, 4'd1,4'd1,1'b0,4'h1, 4'd3,4'd4,1'b0,4'h2, 1'b1,4'd7, 1'b1,1'b0};
    hold[2] = '{1'b1,1'b1, 4'd1,4'd1,1'b0,4'h1, 4'd3,4'd4,1'b0,4'h2, 1'b0,4'd2, 1'b1,1'b0};
    hold[3] = '{1'b1,1'b1, 4'd1,4'd1,1'b0,4'h1, 4'd3,4'd4,1'b0,4'h2, 1'b1,4'd7, 1'b0,1'b0};
    t3[0]   = '{1'b0,1'b1, 4'd0,4'd0,1'b0,4'h1, 4'd5,4'd5,1'b1,4'h2, 1'b1,4'd11, 1'b0,1'b0};
    t3[1]   = '{1'b1,1'b0, 4'd2,4'd3,1'b0,4'h1, 4'd0,4'd0,1'b0,4'h2, 1'b0,4'd5,  1'b0,1'b0};
    t3[2]   = '{1'b1,1'b1, 4'd1,4'd0,1'b0,4'h1, 4'd8,4'd1,1'b0,4'h2, 1'b0,4'd1,  1'b0,1'b0};

    sel3 = 1'b0;
    reset = 1'b1;
    a0 = 4'd0; b0 = 4'd0; cin0 = 1'b0; op0 = 4'd0;
    a1 = 4'd0; b1 = 4'd0; cin1 = 1'b0; op1 = 4'd0;
    r1_req0 = 1'b0; r1_req1 = 1'b0; r3_req0 = 1'b0; r3_req1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", o1_busy, 0);
    chk("rst_en", o1_en, 0);
    chk("rst_done", {o1_done0, o1_done1}, 0);
    chk("rst_result", o1_result, 0);
    chk("rst_grant", o1_grant, 0);
    chk("rst_alu_ops", {o1_a, o1_b, o1_op, o1_cin}, 0);
    chk("rst3_state", {o3_busy, o3_en, o3_done0, o3_done1, o3_result}, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {o1_en, o1_busy, o1_done0, o1_done1}, 0);
      chk("idle_result", o1_result, 0);
    end

    for (int i = 0; i < 7; i++) run_tx(tbl[i], 1, $sformatf("vec%0d", i));
    for (int i = 0; i < 4; i++) run_tx(hold[i], 1, $sformatf("alt%0d", i));

    // Latency 3 instance: start from a clean reset.
    sel3 = 1'b1;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    run_tx(t3[0], 3, "lat3_req1");
    run_tx(t3[1], 3, "lat3_req0");

    // Abort an operation in WAIT with reset; last_grant must return to 1.
    @(negedge clk);
    a0 = 4'd4; b0 = 4'd4; cin0 = 1'b0; op0 = 4'h1;
    r3_req0 = 1'b1;
    @(negedge clk);
    chk("abort_issue_en", o3_en, 1);
    @(negedge clk);
    chk("abort_wait_busy", o3_busy, 1);
    chk("abort_wait_en", o3_en, 0);
    r3_req0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", o3_busy, 0);
    chk("abort_result", o3_result, 0);
    chk("abort_grant", o3_grant, 0);
    chk("abort_alu_a", o3_a, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", {o3_done0, o3_done1, o3_busy}, 0);
    end
    run_tx(t3[2], 3, "after_abort_tie");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 4-bit ALU between two requesters: the self-test controller (port 0) and a user/keypad path (port 1).
- Arbitrates with round-robin priority and latches the winner's operands.
- Sequences the ALU enable and waits the ALU's registered latency.
- Returns the 4-bit result to the winner with a one-cycle done pulse. Sits between the requesters and the alu instance inside the calculator top.

Parameters:
ALU_LAT, 1, cycles from the alu_en cycle to alu_y valid; legal range 1..7.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 operation request (level)
a0  input  4  requester 0 operand A
b0  input  4  requester 0 operand B
cin0  input  1  requester 0 carry-in
op0  input  4  requester 0 op_code
done0  output  1  one-cycle pulse: requester 0 result valid on result
req1  input  1  requester 1 operation request (level)
a1  input  4  requester 1 operand A
b1  input  4  requester 1 operand B
cin1  input  1  requester 1 carry-in
op1  input  4  requester 1 op_code
done1  output  1  one-cycle pulse: requester 1 result valid on result
result  output  4  captured ALU result, held until the next capture
grant_id  output  1  id of the current or most recent grant
busy  output  1  high whenever state is not IDLE
alu_a  output  4  to ALU a
alu_b  output  4  to ALU b
alu_cin  output  1  to ALU c_in
alu_op  output  4  to ALU op_code
alu_en  output  1  to ALU en
alu_y  input  4  from ALU y

Behaviour:
- Reset (synchronous, overrides everything, legal mid-transaction):
  - state=IDLE; done0=done1=0; result=0; grant_id=0; busy=0.
  - alu_a=alu_b=alu_op=0; alu_cin=0; alu_en=0.
  - last_grant=1, so req0 wins the first tie.
  - Any in-flight operation is abandoned; no done is issued for it.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - Samples req0/req1 at each edge.
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last_grant wins (strict alternation).
  - On a win: latch that requester's a/b/cin/op into alu_a/alu_b/alu_cin/alu_op; set grant_id; go to ISSUE.
- ISSUE:
  - Exactly one cycle with alu_en=1.
  - Load a 3-bit wait counter with ALU_LAT; go to WAIT.
- WAIT:
  - alu_en=0; counter decrements each cycle.
  - On the cycle the counter reaches 1, register alu_y into result and go to DONE.
  - WAIT lasts exactly ALU_LAT cycles.
- DONE:
  - done<grant_id>=1 for this cycle only; the other done stays 0.
  - last_grant<=grant_id; go to IDLE.
- Latency: req sampled high at IDLE edge k gives ISSUE in cycle k+1, WAIT in cycles k+2..k+1+ALU_LAT, and done high in cycle k+2+ALU_LAT. Back-to-back throughput is one operation per 3+ALU_LAT cycles.
- Operands and req are sampled only in IDLE. Changing them or dropping req after the grant does not affect the in-flight operation; done still pulses.
- A requester that keeps req high after its done is re-arbitrated in IDLE. With both requesting, grants alternate 0,1,0,1.
- alu_a/alu_b/alu_cin/alu_op hold their latched values outside IDLE transitions; no glitching while alu_en is low.
- result and grant_id hold their values until the next DONE/grant.
- done0 and done1 are never high in the same cycle.

Test Plan:
- Reset then idle: no req for 10 cycles -> alu_en, busy, done0, done1 stay 0; result=0.
- Single request, ALU_LAT=1: req0=1, a0=3, b0=5, cin0=0, op0=ADD, model alu_y=8 -> alu_en high exactly one cycle with alu_a=3, alu_b=5; done0 pulses at cycle k+3; result=8; grant_id=0.
- Simultaneous requests held: req0=req1=1 continuously for 4 transactions -> grant order 0,1,0,1; each done pulse exactly one cycle; no overlap.
- Operand change after grant: req1 with a1=2, b1=1; change a1 to 9 during WAIT -> alu_a stays 2 until done1.
- ALU_LAT=3: req1 -> done1 arrives 5 cycles after the sampling edge; result captures the alu_y value present 3 cycles after alu_en.
- Reset mid-operation: assert reset during WAIT -> next cycle state is IDLE, no done pulse, result=0, last_grant=1, so a later simultaneous request grants 0.
